// File: rtl/trip_display.sv
`default_nettype none
// ============================================================================
// Module   : trip_display
// Purpose  : Three-digit multiplexed 7-segment driver for the trip timer.
//            Shows H.MM with a blinking decimal point after the hour digit.
//            Minutes are split into BCD tens/units by a serial subtract-by-ten
//            engine. Inputs are captured once per scan frame, so a frame
//            never mixes old and new digits.
// Ports    : clock  - system clock, rising edge
//            nRst   - asynchronous reset, active low
//            hour   - trip hours (saturated to 9)
//            mins   - trip minutes (saturated to 59)
//            nTest  - lamp test, active low
//            seg    - segments {g,f,e,d,c,b,a}, active high (registered)
//            dp     - decimal point, active high (registered)
//            digit  - one-hot digit enable {hour, min tens, min units}
// Revision : 1.0 - initial release
// ============================================================================
module trip_display #(
    parameter int SCAN_DIV = 32,
    parameter int HALF_SEC = 6400
) (
    input  logic       clock,
    input  logic       nRst,
    input  logic [3:0] hour,
    input  logic [9:0] mins,
    input  logic       nTest,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] digit
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BC_W = $clog2(2 * HALF_SEC);

    localparam logic [SC_W-1:0] c_sc_last  = SC_W'(SCAN_DIV - 1);
    localparam logic [BC_W-1:0] c_bc_last  = BC_W'(2 * HALF_SEC - 1);
    localparam logic [BC_W-1:0] c_bc_half  = BC_W'(HALF_SEC);

    // Conversion FSM encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // ------------------------------------------------------------------
    // Scan and blink counters
    // ------------------------------------------------------------------
    logic [SC_W-1:0] sc_q,  sc_d;
    logic [1:0]      idx_q, idx_d;
    logic [BC_W-1:0] bc_q,  bc_d;
    logic            w_sc_wrap;
    logic            w_frame_bnd;

    always_comb begin
        w_sc_wrap   = (sc_q == c_sc_last);
        w_frame_bnd = w_sc_wrap && (idx_q == 2'd2);
        sc_d        = w_sc_wrap ? '0 : sc_q + SC_W'(1);
        idx_d       = idx_q;
        if (w_sc_wrap) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        bc_d = (bc_q == c_bc_last) ? '0 : bc_q + BC_W'(1);
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            sc_q  <= '0;
            idx_q <= 2'd0;
            bc_q  <= '0;
        end else begin
            sc_q  <= sc_d;
            idx_q <= idx_d;
            bc_q  <= bc_d;
        end
    end

    // ------------------------------------------------------------------
    // Input saturation (applied before capture)
    // ------------------------------------------------------------------
    logic [3:0] w_hour_sat;
    logic [5:0] w_mins_sat;

    always_comb begin
        w_hour_sat = (hour > 4'd9)   ? 4'd9  : hour;
        // Any of bits [9:6] set is already above 59.
        w_mins_sat = (mins > 10'd59) ? 6'd59 : mins[5:0];
    end

    // ------------------------------------------------------------------
    // Conversion FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic       w_capture;   // start a new conversion
    logic       w_sub;       // subtract ten this cycle
    logic       w_publish;   // move finished result to the shown digits

    logic [3:0] h_cap_q, h_cap_d;
    logic [5:0] rem_q,   rem_d;
    logic [2:0] tens_q,  tens_d;

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (w_frame_bnd) state_d = c_st_load;
            c_st_load: state_d = c_st_div;
            c_st_div:  if (rem_q < 6'd10) state_d = c_st_done;
            c_st_done: if (w_frame_bnd) state_d = c_st_load;
            default:   state_d = c_st_idle;
        endcase
    end

    always_comb begin
        w_capture = w_frame_bnd && ((state_q == c_st_idle) || (state_q == c_st_done));
        w_sub     = (state_q == c_st_div) && (rem_q >= 6'd10);
        w_publish = w_frame_bnd && (state_q == c_st_done);
    end

    // Conversion datapath
    always_comb begin
        h_cap_d = h_cap_q;
        rem_d   = rem_q;
        tens_d  = tens_q;
        if (w_capture) begin
            h_cap_d = w_hour_sat;
            rem_d   = w_mins_sat;
            tens_d  = 3'd0;
        end else if (w_sub) begin
            rem_d   = rem_q - 6'd10;
            tens_d  = tens_q + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            h_cap_q <= 4'd0;
            rem_q   <= 6'd0;
            tens_q  <= 3'd0;
        end else begin
            h_cap_q <= h_cap_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
        end
    end

    // ------------------------------------------------------------------
    // Shown digits: only refreshed on a frame boundary from a DONE result
    // ------------------------------------------------------------------
    logic [3:0] show_h_q, show_h_d;
    logic [2:0] show_t_q, show_t_d;
    logic [3:0] show_u_q, show_u_d;

    always_comb begin
        show_h_d = show_h_q;
        show_t_d = show_t_q;
        show_u_d = show_u_q;
        if (w_publish) begin
            show_h_d = h_cap_q;
            show_t_d = tens_q;
            show_u_d = rem_q[3:0];   // rem < 10 in DONE
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            show_h_q <= 4'd0;
            show_t_q <= 3'd0;
            show_u_q <= 4'd0;
        end else begin
            show_h_q <= show_h_d;
            show_t_q <= show_t_d;
            show_u_q <= show_u_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered, one cycle behind sc/idx/bc)
    // ------------------------------------------------------------------
    logic [3:0] w_bcd;
    logic [6:0] w_seg_code;
    logic [6:0] seg_d;
    logic       dp_d;
    logic [2:0] digit_d;

    always_comb begin
        case (idx_q)
            2'd0:    w_bcd = show_u_q;
            2'd1:    w_bcd = {1'b0, show_t_q};
            default: w_bcd = show_h_q;
        endcase

        case (w_bcd)
            4'd0:    w_seg_code = 7'h3F;
            4'd1:    w_seg_code = 7'h06;
            4'd2:    w_seg_code = 7'h5B;
            4'd3:    w_seg_code = 7'h4F;
            4'd4:    w_seg_code = 7'h66;
            4'd5:    w_seg_code = 7'h6D;
            4'd6:    w_seg_code = 7'h7D;
            4'd7:    w_seg_code = 7'h07;
            4'd8:    w_seg_code = 7'h7F;
            4'd9:    w_seg_code = 7'h6F;
            default: w_seg_code = 7'h00;
        endcase

        case (idx_q)
            2'd0:    digit_d = 3'b001;
            2'd1:    digit_d = 3'b010;
            2'd2:    digit_d = 3'b100;
            default: digit_d = 3'b000;
        endcase

        if (!nTest) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            seg_d = w_seg_code;
            dp_d  = (idx_q == 2'd2) && (bc_q < c_bc_half);
        end
    end

    always_ff @(posedge clock or negedge nRst) begin
        if (!nRst) begin
            seg   <= 7'h00;
            dp    <= 1'b0;
            digit <= 3'b000;
        end else begin
            seg   <= seg_d;
            dp    <= dp_d;
            digit <= digit_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trip_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_trip_display
// Purpose  : Scoreboard bench for trip_display. A frame-level reference model
//            predicts every output cycle; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trip_display;

    localparam int SD = 4;
    localparam int HS = 7;
    localparam int FR = 3 * SD;

    logic       clock = 1'b0;
    logic       nRst  = 1'b0;
    logic [3:0] hour  = 4'd0;
    logic [9:0] mins  = 10'd0;
    logic       nTest = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] digit;

    trip_display #(.SCAN_DIV(SD), .HALF_SEC(HS)) dut (
        .clock (clock),
        .nRst  (nRst),
        .hour  (hour),
        .mins  (mins),
        .nTest (nTest),
        .seg   (seg),
        .dp    (dp),
        .digit (digit)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] digit;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: k = clock edges since reset release.
    int k;
    int cur_h, cur_t, cur_u;
    int pend_h, pend_t, pend_u;
    bit pend_v;

    function automatic void model_reset();
        k      = 0;
        cur_h  = 0; cur_t = 0; cur_u = 0;
        pend_h = 0; pend_t = 0; pend_u = 0;
        pend_v = 1'b0;
    endfunction

    // Predict the output produced by this edge, then advance the model.
    function automatic void model_edge();
        int   idx, bc, dval, hs, ms;
        exp_t e;
        idx  = (k / SD) % 3;
        bc   = k % (2 * HS);
        dval = (idx == 0) ? cur_u : (idx == 1) ? cur_t : cur_h;
        e.digit = 3'(1 << idx);
        if (nTest) begin
            e.seg = seg_tab[dval];
            e.dp  = (idx == 2) && (bc < HS);
        end else begin
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
        exp_q.push_back(e);
        // Frame boundary: publish the previous frame's sample, take a new one.
        if (k % FR == FR - 1) begin
            if (pend_v) begin
                cur_h = pend_h; cur_t = pend_t; cur_u = pend_u;
            end
            hs = (int'(hour) > 9)  ? 9  : int'(hour);
            ms = (int'(mins) > 59) ? 59 : int'(mins);
            pend_h = hs;
            pend_t = ms / 10;
            pend_u = ms % 10;
            pend_v = 1'b1;
        end
        k++;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: compares each presented output against the scoreboard.
    exp_t got, want;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (nRst && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = '{digit: digit, seg: seg, dp: dp};
                n_checks++;
                if (got == want) n_pass++;
                else $display("FAIL scan k=%0d: got digit=%b seg=%h dp=%b, expected digit=%b seg=%h dp=%b",
                              k, got.digit, got.seg, got.dp, want.digit, want.seg, want.dp);
            end
        end
    end

    // One clock: edge, model prediction, back to the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic run(input int h, input int m, input int n);
        hour = 4'(h);
        mins = 10'(m);
        repeat (n) cycle();
    endtask

    task automatic run_random(input int segs);
        for (int i = 0; i < segs; i++) begin
            nTest = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                run($urandom_range(0, 15), $urandom_range(0, 1023), $urandom_range(1, 30));
            else
                run($urandom_range(0, 9), $urandom_range(0, 70), $urandom_range(1, 30));
        end
        nTest = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_seg",   int'(seg),   0);
        chk("reset_dp",    int'(dp),    0);
        chk("reset_digit", int'(digit), 0);

        nRst = 1'b1;
        run(3, 47, 3 * FR);
        run(9, 59, 3 * FR);
        run(12, 63, 3 * FR);
        run(4, 0, 3 * FR);
        // Change minutes mid-frame: current and in-flight frames keep 12.
        run(2, 12, 3 * FR + SD + 2);
        run(2, 58, 3 * FR);
        // Lamp test across a full frame, then release.
        nTest = 1'b0;
        run(2, 58, FR + 3);
        nTest = 1'b1;
        run(2, 58, FR);

        run_random(40);

        // Reset while the divider is busy (two edges after a boundary).
        hour = 4'd7;
        mins = 10'd59;
        while (k % FR != 2) cycle();
        #2 nRst = 1'b0;
        #1;
        chk("midrst_seg",   int'(seg),   0);
        chk("midrst_dp",    int'(dp),    0);
        chk("midrst_digit", int'(digit), 0);
        @(negedge clock);
        @(negedge clock);
        model_reset();
        nRst = 1'b1;
        run(6, 33, 3 * FR);
        run_random(30);

        @(posedge clock);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
